// File: rtl/gmii_arb_pkg.sv
// Shared types and constants for the GMII transmit arbiter.
package gmii_arb_pkg;

    // Ethernet defaults: 12 byte-time inter-frame gap and the longest
    // frame including preamble and SFD.
    localparam int ETH_MIN_IFG   = 12;
    localparam int ETH_MAX_FRAME = 1526;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_START,
        S_XMIT,
        S_DRAIN,
        S_GAP
    } arb_state_t;

    // Width of the shared counter: enough to hold the largest of the
    // frame limit, the start timeout and the gap length.
    function automatic int cnt_width(input int max_bytes,
                                     input int start_timeout,
                                     input int ifg_cycles);
        int m;
        m = max_bytes;
        if (start_timeout > m) m = start_timeout;
        if (ifg_cycles > m)    m = ifg_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin requester selection: first asserted request at or after
// the pointer, wrapping modulo N_REQ. Purely combinational.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    int w_pos;

    // Scan requesters starting at the pointer; the first hit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path
        // leaves a value unassigned, which would infer a latch.
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_pos    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            w_pos = (int'(i_ptr) + i) % N_REQ;
            if (!o_valid && i_req[w_pos]) begin
                o_valid         = 1'b1;
                o_onehot[w_pos] = 1'b1;
                o_idx           = IDX_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/gmii_tx_arbiter.sv
// Shares one GMII transmit path between N_REQ frame sources: round-robin
// grant, one register stage on the byte stream, forced inter-frame gap,
// and recovery from sources that never start or overrun the frame limit.
module gmii_tx_arbiter
    import gmii_arb_pkg::*;
#(
    parameter int N_REQ         = 2,
    parameter int IFG_CYCLES    = ETH_MIN_IFG,
    parameter int START_TIMEOUT = 64,
    parameter int MAX_BYTES     = ETH_MAX_FRAME
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    output logic [N_REQ-1:0]     grant,
    input  logic [8*N_REQ-1:0]   src_txd,
    input  logic [N_REQ-1:0]     src_txen,
    output logic [7:0]           gmii_txd,
    output logic                 gmii_txen,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 err_overrun
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = cnt_width(MAX_BYTES, START_TIMEOUT, IFG_CYCLES);

    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_MAX      = CNT_W'(MAX_BYTES);
    localparam logic [CNT_W-1:0] C_TO_LAST  = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_IFG_LAST = CNT_W'(IFG_CYCLES - 1);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_REQ - 1);

    arb_state_t         r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [N_REQ-1:0]   r_grant, w_grant_nxt;
    logic [IDX_W-1:0]   r_sel, w_sel_nxt;
    logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [7:0]         r_txd;
    logic               r_txen;
    logic               r_err_to;
    logic               r_err_ov;

    logic               w_fwd;
    logic               w_err_to;
    logic               w_err_ov;
    logic [N_REQ-1:0]   w_pick_onehot;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_valid;
    logic [7:0]         w_src_bytes [N_REQ];
    logic               w_src_en;
    logic [7:0]         w_src_byte;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req    (req),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    for (genvar g = 0; g < N_REQ; g++) begin : g_split
        assign w_src_bytes[g] = src_txd[8*g +: 8];
    end

    // Only the selected source is ever looked at; the others are ignored.
    assign w_src_en   = src_txen[r_sel];
    assign w_src_byte = w_src_bytes[r_sel];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic plus next values for grant, selection, pointer and
    // the shared counter (timeout, byte count or gap count by state).
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_grant_nxt  = r_grant;
        w_sel_nxt    = r_sel;
        w_rr_ptr_nxt = r_rr_ptr;
        w_fwd        = 1'b0;
        w_err_to     = 1'b0;
        w_err_ov     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_pick_valid) begin
                    w_grant_nxt  = w_pick_onehot;
                    w_sel_nxt    = w_pick_idx;
                    w_rr_ptr_nxt = (w_pick_idx == C_LAST_IDX) ? '0
                                                              : w_pick_idx + IDX_W'(1);
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_WAIT_START;
                end
            end

            S_WAIT_START: begin
                if (w_src_en) begin
                    // First byte goes straight out; it is byte 1 of the frame.
                    w_fwd       = 1'b1;
                    w_cnt_nxt   = C_ONE;
                    w_state_nxt = S_XMIT;
                end else if (r_cnt >= C_TO_LAST) begin
                    w_err_to    = 1'b1;
                    w_grant_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_GAP;
                end else begin
                    w_cnt_nxt   = r_cnt + C_ONE;
                end
            end

            S_XMIT: begin
                if (!w_src_en) begin
                    w_grant_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_GAP;
                end else if (r_cnt >= C_MAX) begin
                    // One byte past the limit: cut the frame, swallow the rest.
                    w_err_ov    = 1'b1;
                    w_grant_nxt = '0;
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_fwd       = 1'b1;
                    w_cnt_nxt   = r_cnt + C_ONE;
                end
            end

            S_DRAIN: begin
                if (!w_src_en) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_GAP;
                end
            end

            S_GAP: begin
                if (r_cnt >= C_IFG_LAST) w_state_nxt = S_IDLE;
                else                     w_cnt_nxt   = r_cnt + C_ONE;
            end

            default: begin
                w_grant_nxt = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Control registers and the single output register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_grant  <= '0;
            r_sel    <= '0;
            r_rr_ptr <= '0;
            r_txd    <= 8'h00;
            r_txen   <= 1'b0;
            r_err_to <= 1'b0;
            r_err_ov <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_grant  <= w_grant_nxt;
            r_sel    <= w_sel_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_txd    <= w_fwd ? w_src_byte : 8'h00;
            r_txen   <= w_fwd;
            r_err_to <= w_err_to;
            r_err_ov <= w_err_ov;
        end
    end

    assign grant       = r_grant;
    assign gmii_txd    = r_txd;
    assign gmii_txen   = r_txen;
    assign busy        = (r_state != S_IDLE);
    assign err_timeout = r_err_to;
    assign err_overrun = r_err_ov;

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Self-checking bench for gmii_tx_arbiter: bytes are queued as they are
// driven and popped as they appear on the GMII side.
module tb_gmii_tx_arbiter;

    localparam int N_REQ = 2;
    localparam int IFG   = 12;
    localparam int TO    = 64;
    localparam int MAXB  = 1526;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req;
    logic [N_REQ-1:0]     grant;
    logic [8*N_REQ-1:0]   src_txd;
    logic [N_REQ-1:0]     src_txen;
    logic [7:0]           gmii_txd;
    logic                 gmii_txen;
    logic                 busy;
    logic                 err_timeout;
    logic                 err_overrun;

    always #4 clk = ~clk;

    gmii_tx_arbiter #(
        .N_REQ         (N_REQ),
        .IFG_CYCLES    (IFG),
        .START_TIMEOUT (TO),
        .MAX_BYTES     (MAXB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .src_txd     (src_txd),
        .src_txen    (src_txen),
        .gmii_txd    (gmii_txd),
        .gmii_txen   (gmii_txen),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: every enabled GMII byte must be the next expected one.
    always @(negedge clk) begin
        if (!rst && gmii_txen) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", exp_q.size(), 1);
            end else begin
                mon_exp = exp_q.pop_front();
                check("gmii_byte", gmii_txd, mon_exp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] frame_byte(input int i, input int seed);
        if (i < 7)       return 8'h55;
        else if (i == 7) return 8'hD5;
        else             return 8'(i - 8 + seed);
    endfunction

    task automatic drive_byte(input int s, input logic [7:0] b, input bit expect_out);
        src_txen[s]       = 1'b1;
        src_txd[s*8 +: 8] = b;
        if (expect_out) exp_q.push_back(b);
    endtask

    task automatic send_frame(input int s, input int len, input int seed);
        for (int i = 0; i < len; i++) begin
            drive_byte(s, frame_byte(i, seed), 1'b1);
            tick();
            if (i == 0) begin
                check("first_byte_txen", gmii_txen, 1'b1);
                check("first_byte_txd", gmii_txd, frame_byte(0, seed));
            end
        end
        src_txen[s]       = 1'b0;
        src_txd[s*8 +: 8] = 8'h00;
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (grant == '0 && n < 500) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 500) begin
            tick();
            n++;
        end
    endtask

    task automatic reset_dut();
        rst      = 1'b1;
        req      = '0;
        src_txen = '0;
        src_txd  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int n, m, ov_at, ov_cnt;
    bit drain_grant;

    initial begin
        rst      = 1'b1;
        req      = '0;
        src_txen = '0;
        src_txd  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", grant, 0);
        check("rst_txd", gmii_txd, 8'h00);
        check("rst_txen", gmii_txen, 0);
        check("rst_busy", busy, 0);
        check("rst_err_to", err_timeout, 0);
        check("rst_err_ov", err_overrun, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // Single source 0, 72-byte frame.
        req = 2'b01;
        tick();
        check("t1_grant", grant, 2'b01);
        check("t1_busy", busy, 1);
        req = '0;
        send_frame(0, 72, 0);
        tick();
        n = 1;
        check("t1_grant_drop", grant, 0);
        while (busy && n < 500) begin
            tick();
            n++;
        end
        check("t1_busy_tail", n, IFG + 1);

        // Both sources request continuously: strict alternation.
        reset_dut();
        req = 2'b11;
        for (int f = 0; f < 4; f++) begin
            wait_grant(n);
            check("t2_wait", n, (f == 0) ? 1 : IFG + 1);
            check("t2_grant", grant, (f % 2 == 0) ? 2'b01 : 2'b10);
            send_frame(f % 2, 60, f * 16);
            if (f == 3) req = '0;
            tick();
            check("t2_drop", grant, 0);
        end
        wait_idle(n);
        check("t2_idle", n, IFG);
        repeat (3) tick();
        check("t2_no_grant", grant, 0);

        // Source 1 granted but silent; source 0 noise must be ignored.
        req = 2'b10;
        tick();
        check("t3_grant1", grant, 2'b10);
        req          = 2'b01;
        src_txen[0]  = 1'b1;
        src_txd[7:0] = 8'hEE;
        n = 0;
        while (!err_timeout && n < 500) begin
            tick();
            n++;
        end
        check("t3_timeout_at", n, TO);
        check("t3_grant_drop", grant, 0);
        src_txen[0]  = 1'b0;
        src_txd[7:0] = 8'h00;
        tick();
        check("t3_pulse", err_timeout, 0);
        wait_grant(m);
        check("t3_regrant_wait", m + 1, IFG + 1);
        check("t3_regrant", grant, 2'b01);
        req = '0;
        send_frame(0, 20, 8'h40);
        tick();
        wait_idle(n);

        // Source 0 overruns the frame limit; source 1 waits behind it.
        req = 2'b01;
        tick();
        check("t4_grant0", grant, 2'b01);
        req = 2'b10;
        ov_at = -1;
        ov_cnt = 0;
        drain_grant = 1'b0;
        for (int i = 0; i < 1600; i++) begin
            drive_byte(0, frame_byte(i, 0), i < MAXB);
            tick();
            if (err_overrun) begin
                ov_cnt++;
                if (ov_at < 0) ov_at = i;
            end
            if (i == MAXB) begin
                check("t4_txen_cut", gmii_txen, 0);
                check("t4_grant_cut", grant, 0);
            end
            if (i > MAXB && grant != '0) drain_grant = 1'b1;
        end
        check("t4_ov_at", ov_at, MAXB);
        check("t4_ov_cnt", ov_cnt, 1);
        check("t4_drain_grant", drain_grant, 0);
        src_txen[0]  = 1'b0;
        src_txd[7:0] = 8'h00;
        wait_grant(n);
        check("t4_regrant_wait", n, IFG + 2);
        check("t4_regrant", grant, 2'b10);
        req = '0;
        send_frame(1, 10, 8'h80);
        tick();
        wait_idle(n);

        // Reset in the middle of a source 0 frame (pointer then at 1).
        req = 2'b01;
        tick();
        check("t5_grant0", grant, 2'b01);
        req = '0;
        for (int i = 0; i < 30; i++) begin
            drive_byte(0, frame_byte(i, 8'h10), 1'b1);
            tick();
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t5_rst_grant", grant, 0);
        check("t5_rst_txen", gmii_txen, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_txd", gmii_txd, 8'h00);
        src_txen = '0;
        src_txd  = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_sb_empty", exp_q.size(), 0);
        req = 2'b11;
        tick();
        check("t5_rr_reset", grant, 2'b01);
        req = '0;
        send_frame(0, 16, 8'h20);
        tick();
        wait_idle(n);
        check("t5_idle", n, IFG);

        repeat (2) tick();
        check("sb_final", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
